framebuffer_scanout: RTL
========================

# framebuffer_scanout

Receives the pixel-plot stream produced by the screen/tile copy engine (x, y, 6-bit colour, write strobe) and stores it in a 320×240×6-bit framebuffer. Continuously scans that framebuffer out as a 640×480@60 Hz VGA signal with 2× pixel doubling. This is the display end of the plot interface. It sits between the copy engine and the DE1 VGA DAC pins, and returns a per-frame pulse so game logic can time its refreshes.

## Interface
Parameters:
- WIDTH, 320, framebuffer columns
- HEIGHT, 240, framebuffer rows
- BITS_PER_COLOUR, 2, bits per channel in stored colour (stored word = 3×BITS_PER_COLOUR, order R,G,B MSB→LSB)

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  one clock; reset is asynchronous and active-high (asserted when 1, despite the name)
- x  in  9  plot column
- y  in  8  plot row
- colour  in  6  plot colour {R[1:0],G[1:0],B[1:0]}
- plot  in  1  write strobe; one pixel written per cycle high
- vga_clk  out  1  25 MHz pixel clock to DAC
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  low outside visible area
- vga_r, vga_g, vga_b  out  8 each  DAC colour
- frame_done  out  1  one-clk pulse at start of vertical front porch

## Operation
- Write side: on any clk edge with plot=1 and x<WIDTH and y<HEIGHT, write colour to mem[y*WIDTH+x]. Out-of-range plots are silently dropped. No back-pressure: every in-range strobe is accepted.
- Phase register ph toggles every clk, reset 0. A pixel tick occurs on clk edges where ph=1. vga_clk = ph.
- Counters hc (0–799) and vc (0–524) advance on pixel ticks. hc wraps 799→0 and increments vc. vc wraps 524→0.
- Horizontal timing: visible 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- Vertical timing: visible 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- Read address = (vc>>1)*WIDTH + (hc>>1), computed combinationally. Memory read is registered on every clk, giving 1-clk latency.
- Output stage loads on pixel ticks from the read data and from the hc/vc-derived sync/blank. Outside the visible area, RGB is forced to 0.
- Channel expansion: 2-bit c → 8 bits {c,c,c,c} (2'b10 → 8'hAA, 2'b11 → 8'hFF).
- Read-during-write to the same address returns the old data. The new value appears on the next frame.
- frame_done is high for exactly one clk, on the tick where vc becomes 480 (hc=0).

## Timing
- Reset values: ph=0, hc=0, vc=0, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_done=0. Framebuffer contents are not cleared.
- Reset mid-frame: all of the above take effect immediately (asynchronous). Scan restarts at (0,0) on the first tick after release.
- All VGA outputs are registered and lag the counters by exactly one pixel tick (2 clks), mutually aligned. Pixel (hc,vc) appears on the outputs during the tick after the counter held (hc,vc).
- Write-to-visible latency: a pixel written at least 2 clks before its address is read appears in the current frame.
- Simultaneous write and scan of the same pixel is allowed with no stall. The scan sees the old value, per the read-during-write rule above.
- Frame period: 800×525 ticks = 840000 clks.

## Test plan
- Reset then free-run: vga_hs low for exactly 96 ticks (192 clks) every 800 ticks. vga_vs low for exactly 2 lines (1600 ticks). First vga_hs falling edge 657 ticks after reset release.
- Plot (x=5, y=3, colour=6'b100111): next frame, output pixels hc=10,11 on vc=6,7 show R=8'hAA, G=8'h55, B=8'hFF; neighbouring pixel at hc=12 is unchanged.
- Plot (x=320, y=0) and (x=0, y=240) with colour 6'b111111: no framebuffer location changes; full-frame readback is identical to before.
- During blanking (hc=700) with the framebuffer fully 6'b111111: vga_blank_n=0 and RGB=0.
- frame_done: exactly one 1-clk pulse per 840000 clks, aligned to vc=480, hc=0.
- Assert reset_n for 3 clks at vc=200: outputs go to reset values within the same cycle. After release, the next frame_done arrives 480 lines later.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// Plot-stream framebuffer with a 640x480@60 VGA scanout, each stored pixel doubled 2x2.
// The write port takes one pixel per clk; the read port is scanned continuously at half the clk rate.
module framebuffer_scanout #(
    parameter int WIDTH           = 320,
    parameter int HEIGHT          = 240,
    parameter int BITS_PER_COLOUR = 2,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [8:0]                     x,
    input  logic [7:0]                     y,
    input  logic [3*BITS_PER_COLOUR-1:0]   colour,
    input  logic                           plot,
    output logic                           vga_clk,
    output logic                           vga_hs,
    output logic                           vga_vs,
    output logic                           vga_blank_n,
    output logic [7:0]                     vga_r,
    output logic [7:0]                     vga_g,
    output logic [7:0]                     vga_b,
    output logic                           frame_done
);

    localparam int B       = BITS_PER_COLOUR;
    localparam int CW      = 3 * B;
    localparam int DEPTH   = WIDTH * HEIGHT;
    localparam int AW      = $clog2(DEPTH);
    localparam int H_VIS   = 2 * WIDTH;
    localparam int V_VIS   = 2 * HEIGHT;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
    localparam logic [VW-1:0] V_PRE_FP = VW'(V_VIS - 1);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_VIS + V_FP + V_SYNC);

    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] rdata;
    logic          ph;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic          visible;
    logic          hsync_on;
    logic          vsync_on;

    function automatic logic [7:0] expand(input logic [B-1:0] c);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[B-1-(i % B)];
        end
        return e;
    endfunction

    assign wr_en    = plot && (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign wr_addr  = AW'(32'(y) * WIDTH + 32'(x));
    assign rd_addr  = AW'(32'(vc >> 1) * WIDTH + 32'(hc >> 1));
    assign visible  = (hc < H_VIS_L) && (vc < V_VIS_L);
    assign hsync_on = (hc >= H_SYNC_S) && (hc < H_SYNC_E);
    assign vsync_on = (vc >= V_SYNC_S) && (vc < V_SYNC_E);
    assign vga_clk  = ph;

    // Non-blocking read and write: a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= colour;
        end
        rdata <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ph          <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_done  <= 1'b0;
        end else begin
            ph         <= ~ph;
            frame_done <= 1'b0;
            if (ph) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                    if (vc == V_PRE_FP) begin
                        frame_done <= 1'b1;
                    end
                end else begin
                    hc <= hc + 1'b1;
                end
                // Output stage shows the pixel the counters held before this tick.
                vga_hs      <= ~hsync_on;
                vga_vs      <= ~vsync_on;
                vga_blank_n <= visible;
                vga_r       <= visible ? expand(rdata[CW-1 -: B])  : 8'h00;
                vga_g       <= visible ? expand(rdata[2*B-1 -: B]) : 8'h00;
                vga_b       <= visible ? expand(rdata[B-1:0])      : 8'h00;
            end
        end
    end

endmodule
